// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: buffers hit indices, sets bits in a WORDS x 32 bitmap
// by read-modify-write, counts distinct hits, and serves host word reads.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_CLEAR   | zero one bitmap word per cycle (clr_ptr 0..WORDS-1)
// S_IDLE    | accept a host read, or pop one hit from the FIFO
// S_RMW_RD  | wait one cycle for the bitmap word being updated
// S_RMW_UPD | set the hit bit if it was clear, count it, pulse new_hit
// S_HOST_RD | register the bitmap word as the host response
module cover_toggle_collector #(
    parameter int COVER_TOTAL = 11747,
    parameter int IDX_W       = 14,
    parameter int FIFO_DEPTH  = 4,
    localparam int WORDS      = (COVER_TOTAL + 31) / 32,
    localparam int AW         = $clog2(WORDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hit_valid,
    output logic             hit_ready,
    input  logic [IDX_W-1:0] hit_index,
    input  logic             clear_req,
    input  logic             rd_req_valid,
    output logic             rd_req_ready,
    input  logic [AW-1:0]    rd_req_addr,
    output logic             rd_resp_valid,
    output logic [31:0]      rd_resp_data,
    output logic [IDX_W-1:0] covered_count,
    output logic             new_hit,
    output logic             busy,
    output logic             range_err
);

    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam logic [31:0]   TOTAL_U   = 32'(COVER_TOTAL);
    localparam logic [31:0]   WORDS_U   = 32'(WORDS);
    localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RMW_RD,
        S_RMW_UPD,
        S_HOST_RD
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
    logic [FW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic             new_hit_q, new_hit_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic             range_err_q, range_err_d;
    logic             oob_q, oob_d;

    logic [IDX_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [31:0]      mem [WORDS];
    logic [31:0]      mem_q;

    logic             mem_en, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [31:0]      mem_wdata;
    logic             push, pop, flush;
    logic             fifo_full, fifo_empty;
    logic [IDX_W-1:0] head;

    assign fifo_full  = (fifo_cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign hit_ready  = !fifo_full && (state_q != S_CLEAR);
    assign push       = hit_valid && hit_ready;
    assign head       = fifo_mem[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        idx_d        = idx_q;
        count_d      = count_q;
        new_hit_d    = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        range_err_d  = range_err_q;
        oob_d        = oob_q;
        pop          = 1'b0;
        flush        = 1'b0;
        rd_req_ready = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        // A clear request pre-empts whatever is in flight, with no write or response.
        if (clear_req) begin
            state_d     = S_CLEAR;
            clr_ptr_d   = '0;
            count_d     = '0;
            range_err_d = 1'b0;
            flush       = 1'b1;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = clr_ptr_q;
                    count_d  = '0;
                    if (clr_ptr_q == LAST_WORD) begin
                        clr_ptr_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        clr_ptr_d = clr_ptr_q + AW'(1);
                    end
                end
                S_IDLE: begin
                    rd_req_ready = 1'b1;
                    if (rd_req_valid) begin
                        oob_d    = (32'(rd_req_addr) >= WORDS_U);
                        mem_en   = !oob_d;
                        mem_addr = rd_req_addr;
                        state_d  = S_HOST_RD;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                        if (32'(head) >= TOTAL_U) begin
                            range_err_d = 1'b1;
                        end else begin
                            idx_d    = head;
                            mem_en   = 1'b1;
                            mem_addr = AW'(head >> 5);
                            state_d  = S_RMW_RD;
                        end
                    end
                end
                S_RMW_RD: begin
                    state_d = S_RMW_UPD;
                end
                S_RMW_UPD: begin
                    state_d = S_IDLE;
                    if (!mem_q[idx_q[4:0]]) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = AW'(idx_q >> 5);
                        mem_wdata = mem_q | (32'h1 << idx_q[4:0]);
                        new_hit_d = 1'b1;
                        if (32'(count_q) < TOTAL_U) begin
                            count_d = count_q + IDX_W'(1);
                        end
                    end
                end
                S_HOST_RD: begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = oob_q ? 32'h0 : mem_q;
                end
                default: begin
                    state_d = S_CLEAR;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + FW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + FW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            clr_ptr_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            idx_q        <= '0;
            count_q      <= '0;
            new_hit_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            range_err_q  <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            new_hit_q    <= new_hit_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            range_err_q  <= range_err_d;
            oob_q        <= oob_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= hit_index;
    end

    // Single-port bitmap; read data is valid the cycle after the address.
    always_ff @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_q <= mem[mem_addr];
        end
    end

    assign rd_resp_valid = resp_valid_q;
    assign rd_resp_data  = resp_data_q;
    assign covered_count = count_q;
    assign new_hit       = new_hit_q;
    assign busy          = (state_q == S_CLEAR);
    assign range_err     = range_err_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector: a table of hit/read vectors plus
// hand-written sequences for duplicates, back-pressure, clear abort and reset.
module tb_cover_toggle_collector;

    localparam int IDX_W = 14;
    localparam int AW    = 9;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             hit_valid = 1'b0;
    logic             hit_ready;
    logic [IDX_W-1:0] hit_index = '0;
    logic             clear_req = 1'b0;
    logic             rd_req_valid = 1'b0;
    logic             rd_req_ready;
    logic [AW-1:0]    rd_req_addr = '0;
    logic             rd_resp_valid;
    logic [31:0]      rd_resp_data;
    logic [IDX_W-1:0] covered_count;
    logic             new_hit;
    logic             busy;
    logic             range_err;

    int checks = 0;
    int errors = 0;

    cover_toggle_collector dut (
        .clock         (clock),
        .reset         (reset),
        .hit_valid     (hit_valid),
        .hit_ready     (hit_ready),
        .hit_index     (hit_index),
        .clear_req     (clear_req),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_data  (rd_resp_data),
        .covered_count (covered_count),
        .new_hit       (new_hit),
        .busy          (busy),
        .range_err     (range_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          op;        // 0 = hit, 1 = host read
        int          arg;       // index or word address
        int          exp_new;   // expected new_hit pulses (hit)
        int          exp_cnt;   // expected covered_count (hit)
        logic [31:0] exp_data;  // expected word (read)
        logic        exp_rerr;  // expected range_err (hit)
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clock);
        end
        chk(name, 32'(n), 32'd368);
    endtask

    task automatic do_hit(input int idx, output int pulses, output int lat);
        int b;
        hit_index = IDX_W'(idx);
        hit_valid = 1'b1;
        b = 0;
        while (!hit_ready && b < 50) begin
            b++;
            @(negedge clock);
        end
        chk("hit_accept", 32'(hit_ready), 32'd1);
        @(negedge clock);
        hit_valid = 1'b0;
        pulses = 0;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            if (new_hit) begin
                pulses++;
                if (lat == 0) lat = k;
            end
            @(negedge clock);
        end
    endtask

    task automatic do_read(input int addr, output logic [31:0] data, output int got);
        int b;
        rd_req_addr  = AW'(addr);
        rd_req_valid = 1'b1;
        b = 0;
        while (!rd_req_ready && b < 50) begin
            b++;
            @(negedge clock);
        end
        chk("rd_accept", 32'(rd_req_ready), 32'd1);
        @(negedge clock);
        chk("rd_ready_low_in_host_rd", 32'(rd_req_ready), 32'd0);
        rd_req_valid = 1'b0;
        got  = 0;
        data = '0;
        for (int k = 0; k < 10; k++) begin
            if (rd_resp_valid && got == 0) begin
                got  = 1;
                data = rd_resp_data;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        int          pulses, lat, got, acc, nh, resp, sent, at40, pend;
        logic        saw_full;
        logic [31:0] rdat, last_rd;

        vecs[0]  = '{0, 0,     1, 1, 32'h0,        1'b0};
        vecs[1]  = '{0, 31,    1, 2, 32'h0,        1'b0};
        vecs[2]  = '{0, 32,    1, 3, 32'h0,        1'b0};
        vecs[3]  = '{0, 11746, 1, 4, 32'h0,        1'b0};
        vecs[4]  = '{1, 0,     0, 0, 32'h80000001, 1'b0};
        vecs[5]  = '{1, 1,     0, 0, 32'h00000001, 1'b0};
        vecs[6]  = '{1, 367,   0, 0, 32'h00000004, 1'b0};
        vecs[7]  = '{1, 2,     0, 0, 32'h00000000, 1'b0};
        vecs[8]  = '{0, 11747, 0, 4, 32'h0,        1'b1};
        vecs[9]  = '{0, 7,     1, 5, 32'h0,        1'b1};
        vecs[10] = '{0, 31,    0, 5, 32'h0,        1'b1};
        vecs[11] = '{1, 0,     0, 0, 32'h80000081, 1'b0};
        vecs[12] = '{1, 400,   0, 0, 32'h00000000, 1'b0};

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_hit_ready", 32'(hit_ready), 32'd0);
        chk("rst_rd_req_ready", 32'(rd_req_ready), 32'd0);
        chk("rst_count", 32'(covered_count), 32'd0);
        chk("rst_new_hit", 32'(new_hit), 32'd0);
        chk("rst_resp_valid", 32'(rd_resp_valid), 32'd0);
        chk("rst_resp_data", rd_resp_data, 32'd0);
        chk("rst_range_err", 32'(range_err), 32'd0);
        reset = 1'b0;
        wait_clear("init_clear_cycles");
        chk("init_hit_ready", 32'(hit_ready), 32'd1);
        chk("init_count", 32'(covered_count), 32'd0);

        // Table-driven hits and reads
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].op == 0) begin
                do_hit(vecs[i].arg, pulses, lat);
                chk($sformatf("vec%0d_new_hit", i), 32'(pulses), 32'(vecs[i].exp_new));
                chk($sformatf("vec%0d_count", i), 32'(covered_count), 32'(vecs[i].exp_cnt));
                chk($sformatf("vec%0d_range_err", i), 32'(range_err), 32'(vecs[i].exp_rerr));
                if (vecs[i].exp_new == 1)
                    chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            end else begin
                do_read(vecs[i].arg, rdat, got);
                chk($sformatf("vec%0d_resp_seen", i), 32'(got), 32'd1);
                chk($sformatf("vec%0d_data", i), rdat, vecs[i].exp_data);
            end
        end

        // Index 5 three times back-to-back counts once
        hit_index = IDX_W'(5);
        hit_valid = 1'b1;
        acc = 0; nh = 0; pend = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (pend != 0) begin
                acc++;
                if (acc == 3) hit_valid = 1'b0;
            end
            if (new_hit) nh++;
            pend = (hit_valid && hit_ready) ? 1 : 0;
            @(negedge clock);
        end
        chk("dup_accepted", 32'(acc), 32'd3);
        chk("dup_new_hit", 32'(nh), 32'd1);
        chk("dup_count", 32'(covered_count), 32'd6);
        do_read(0, rdat, got);
        chk("dup_word0", rdat, 32'h800000A1);

        // Host reads held continuously starve the drain; FIFO fills, then drains
        rd_req_addr  = '0;
        rd_req_valid = 1'b1;
        hit_index    = IDX_W'(100);
        hit_valid    = 1'b1;
        sent = 0; nh = 0; resp = 0; at40 = -1; pend = 0;
        saw_full = 1'b0;
        last_rd  = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (pend != 0) begin
                sent++;
                if (sent == 10) hit_valid = 1'b0;
                else hit_index = IDX_W'(100 + sent);
            end
            if (new_hit) nh++;
            if (rd_resp_valid) begin
                resp++;
                last_rd = rd_resp_data;
            end
            if (rd_req_valid && hit_valid && !hit_ready) saw_full = 1'b1;
            if (cyc == 40) begin
                at40 = sent;
                rd_req_valid = 1'b0;
            end
            pend = (hit_valid && hit_ready) ? 1 : 0;
            @(negedge clock);
        end
        chk("bp_accepted_while_reading", 32'(at40), 32'd4);
        chk("bp_hit_ready_dropped", 32'(saw_full), 32'd1);
        chk("bp_host_served", 32'(resp >= 10), 32'd1);
        chk("bp_host_data", last_rd, 32'h800000A1);
        chk("bp_all_sent", 32'(sent), 32'd10);
        chk("bp_new_hits", 32'(nh), 32'd10);
        chk("bp_count", 32'(covered_count), 32'd16);
        do_read(3, rdat, got);
        chk("bp_word3", rdat, 32'h00003FF0);

        // clear_req while the RMW read is outstanding
        hit_index = IDX_W'(200);
        hit_valid = 1'b1;
        @(negedge clock);
        hit_valid = 1'b0;
        @(negedge clock);
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        nh = 0;
        for (int k = 0; k < 3; k++) if (new_hit) nh++;
        wait_clear("abort_clear_cycles");
        repeat (5) begin
            if (new_hit) nh++;
            @(negedge clock);
        end
        chk("abort_new_hit", 32'(nh), 32'd0);
        chk("abort_count", 32'(covered_count), 32'd0);
        chk("abort_range_err", 32'(range_err), 32'd0);
        foreach (vecs[i]) begin
            if (vecs[i].op == 1 && vecs[i].arg < 368) begin
                do_read(vecs[i].arg, rdat, got);
                chk($sformatf("abort_word%0d", vecs[i].arg), rdat, 32'h0);
            end
        end
        do_read(6, rdat, got);
        chk("abort_word6", rdat, 32'h0);

        // Reset in the middle of a hit update
        hit_index = IDX_W'(300);
        hit_valid = 1'b1;
        @(negedge clock);
        hit_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_new_hit", 32'(new_hit), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_hit_ready", 32'(hit_ready), 32'd0);
        reset = 1'b0;
        nh = 0;
        wait_clear("mid_rst_clear_cycles");
        repeat (5) begin
            if (new_hit) nh++;
            @(negedge clock);
        end
        chk("mid_rst_no_pulse", 32'(nh), 32'd0);
        chk("mid_rst_count", 32'(covered_count), 32'd0);
        do_hit(300, pulses, lat);
        chk("post_rst_new_hit", 32'(pulses), 32'd1);
        chk("post_rst_count", 32'(covered_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cover_toggle_collector.md
COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 Parameter COVER_TOTAL, default 11747, number of toggle cover points accepted.
REQ-002 Parameter IDX_W, default 14, width of a cover index (2^IDX_W SHALL be >= COVER_TOTAL).
REQ-003 Parameter FIFO_DEPTH, default 4, hit-event buffer entries (power of two).
REQ-004 Derived constant WORDS = ceil(COVER_TOTAL/32), 368 at defaults; bitmap word address width AW = clog2(WORDS).
REQ-005 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port hit_valid  input  1  a cover hit event is presented.
REQ-008 Port hit_ready  output  1  collector accepts the hit this cycle.
REQ-009 Port hit_index  input  IDX_W  global cover index of the hit.
REQ-010 Port clear_req  input  1  one-cycle request to zero the bitmap and count.
REQ-011 Port rd_req_valid  input  1  host requests one bitmap word.
REQ-012 Port rd_req_ready  output  1  read request accepted this cycle.
REQ-013 Port rd_req_addr  input  AW  bitmap word address.
REQ-014 Port rd_resp_valid  output  1  one-cycle pulse, rd_resp_data valid.
REQ-015 Port rd_resp_data  output  32  bitmap word; bit b = cover point addr*32+b.
REQ-016 Port covered_count  output  IDX_W  number of distinct points hit since last clear.
REQ-017 Port new_hit  output  1  one-cycle pulse when a previously unhit point becomes covered.
REQ-018 Port busy  output  1  high during CLEAR.
REQ-019 Port range_err  output  1  sticky; an out-of-range index was received.

Function
REQ-020 Hits SHALL be accepted into a FIFO of FIFO_DEPTH entries on hit_valid && hit_ready; hit_ready = !fifo_full && state != CLEAR.
REQ-021 Bitmap SHALL be a single-port, WORDS x 32 memory with synchronous read (data one cycle after address).
REQ-022 FSM states: CLEAR, IDLE, RMW_RD, RMW_UPD, HOST_RD.
REQ-023 CLEAR: write zero to word clr_ptr each cycle, clr_ptr 0..WORDS-1; after word WORDS-1 go to IDLE; covered_count held at 0.
REQ-024 IDLE: if rd_req_valid, assert rd_req_ready, issue read of rd_req_addr, go HOST_RD (host read priority over FIFO drain).
REQ-025 IDLE, no host read, FIFO non-empty: pop head; if index >= COVER_TOTAL set range_err, drop, stay IDLE; else issue read of index>>5, go RMW_RD.
REQ-026 RMW_RD: one wait cycle for read data, go RMW_UPD.
REQ-027 RMW_UPD: if bit (index & 31) already set, no write; else write word | (1<<bit), covered_count +1, new_hit pulse; go IDLE.
REQ-028 Hit latency: new_hit SHALL pulse exactly 3 cycles after the pop cycle in IDLE (IDLE, RMW_RD, RMW_UPD, pulse registered on exit).
REQ-029 HOST_RD: rd_resp_data = memory output, rd_resp_valid pulses for one cycle, go IDLE; rd_req_addr >= WORDS returns 0.
REQ-030 rd_req_ready SHALL be low in every state except IDLE.
REQ-031 clear_req in any state SHALL abort the current RMW/host read (no write, no response), flush the FIFO, and enter CLEAR next cycle; range_err cleared.
REQ-032 Simultaneous FIFO push and pop SHALL both occur; push while full is not accepted (hit_ready low).
REQ-033 covered_count SHALL saturate at COVER_TOTAL and never wrap.
REQ-034 Duplicate hits of the same index back-to-back SHALL count once (RMW serialised, no bypass needed).

Reset
REQ-035 On reset assertion, asynchronously: state=CLEAR, clr_ptr=0, FIFO empty, covered_count=0, new_hit=0, rd_resp_valid=0, rd_resp_data=0, range_err=0; busy=1, hit_ready=0, rd_req_ready=0.
REQ-036 After reset deassertion, CLEAR SHALL run WORDS cycles (368) before hit_ready rises.
REQ-037 Reset mid-operation SHALL discard all pending hits and reads without producing any pulse.

Verification
REQ-038 Release reset, hold hit_valid=0 -> busy high 368 cycles, then hit_ready=1, covered_count=0.
REQ-039 Hit indices 0, 31, 32, 11746 -> four new_hit pulses, covered_count=4; read word 0 -> 0x80000001, word 1 -> 0x00000001, word 367 -> bit 2 set (11746 = 367*32+2).
REQ-040 Hit index 5 three times back-to-back -> one new_hit, covered_count=1.
REQ-041 Hit index 11747 -> range_err=1, no new_hit, count unchanged; then index 7 -> counted normally.
REQ-042 Hold hit_valid=1 with 10 distinct indices while rd_req_valid=1 -> hit_ready drops after FIFO fills, host reads served first, all 10 eventually counted.
REQ-043 Pulse clear_req during RMW_RD -> no new_hit, busy for 368 cycles, all words read 0, covered_count=0.
